timing_mode_ctrl: RTL
=====================

// Module: timing_mode_ctrl
// PURPOSE
//  Sequences run-time video mode changes for the HDMI output timing generator. Accepts mode requests over a req/ack
//  handshake and waits for a frame boundary (tg_vs rising edge). Holds the generator in reset while the pixel clock
//  re-locks, then drives the new timing preset. Forces black output for a settle period so the sink never sees a torn frame.
// PARAMETERS
//  DEFAULT_MODE   0        mode applied out of reset (0..3)
//  LOCK_STABLE    255      consecutive sys_clk cycles clk_locked must be high before release (1..255, 8-bit counter)
//  LOCK_TIMEOUT   2**20-1  max cycles waited for lock before abort (1..2**20-1, 20-bit counter)
//  SETTLE_FRAMES  2        frames (tg_vs rising edges) of forced blank after release (1..15)
// PORTS
//  sys_clk        in   1   system clock; all logic in this domain
//  sys_rst_n      in   1   asynchronous active-low reset
//  cfg_req        in   1   level request; sampled only in IDLE
//  cfg_mode       in   2   0=1920x1080 1=1280x720 2=640x480 3=800x600; sampled with cfg_req
//  cfg_ack        out  1   1-cycle pulse: request completed OK
//  cfg_err        out  1   1-cycle pulse: lock timeout, previous mode restored
//  cfg_busy       out  1   high in every state except IDLE
//  tg_vs          in   1   VS from timing generator, active high
//  clk_locked     in   1   pixel PLL lock, already synchronised to sys_clk
//  clk_sel        out  2   PLL frequency select = mode being applied
//  tg_rst_n       out  1   active-low reset to timing generator
//  tg_blank       out  1   forces RGB/DE to zero downstream
//  h_front,h_sync,h_back,h_active  out 13 each  horizontal preset of cur_mode
//  v_front,v_sync,v_back,v_active  out 13 each  vertical preset of cur_mode
//  frame_cnt      out  16  frames since last mode change (see CONFIGURATION)
// BEHAVIOUR
//  All outputs registered. Reset values: state=SETTLE, cur_mode=DEFAULT_MODE, clk_sel=DEFAULT_MODE, tg_rst_n=1,
//   tg_blank=1, cfg_ack=0, cfg_err=0, cfg_busy=1, frame_cnt=0, timing outputs=preset(DEFAULT_MODE).
//  Presets H(fp,sync,bp,act)/V(fp,sync,bp,act): 0: 88,44,148,1920/4,5,36,1080  1: 110,40,220,1280/5,5,20,720
//   2: 16,96,48,640/10,2,33,480  3: 40,128,88,800/1,4,23,600.
//  vs_rise = tg_vs & ~tg_vs_d1 (one register stage; tg_vs_d1 resets to 0).
//  IDLE: cfg_busy=0. cfg_req & cfg_mode==cur_mode -> cfg_ack next cycle, stay IDLE, no reset/blank.
//   cfg_req & cfg_mode!=cur_mode -> latch new_mode, prev_mode=cur_mode -> WAIT_VS.
//  WAIT_VS: on vs_rise -> HOLD: same edge sets tg_rst_n=0, tg_blank=1, clk_sel=new_mode, cur_mode=new_mode, lock_cnt=0, to_cnt=0.
//  HOLD: to_cnt++ each cycle; lock_cnt++ while clk_locked else cleared to 0.
//   lock_cnt==LOCK_STABLE -> tg_rst_n=1 -> SETTLE (frm_cnt=0).
//   to_cnt==LOCK_TIMEOUT first -> cur_mode=clk_sel=prev_mode, tg_rst_n=1, cfg_err pulse -> SETTLE.
//   If both fire on the same cycle, lock wins.
//  SETTLE: count vs_rise; on SETTLE_FRAMES-th -> tg_blank=0 -> IDLE. cfg_ack pulses on that exit unless SETTLE was
//   entered via timeout or from reset.
//  Timing outputs update on the cycle cur_mode changes (registered lookup, 1-cycle latency) and are stable while tg_rst_n=0.
//  cfg_req outside IDLE ignored (no queueing). Reset mid-sequence aborts to the reset state immediately.
//  Latency, OK path: ack <= wait_to_vs + LOCK_STABLE + SETTLE_FRAMES frames + 2 cycles.
// CONFIGURATION
//  TMC_FRAME_CNT_EN defined: frame_cnt increments on each vs_rise, saturates at 16'hFFFF,
//   clears on HOLD entry (including a timeout).
//  Not defined: frame_cnt tied to 0; counter and increment logic are absent.
// STRUCTURE
//  Package timing_mode_pkg: mode encoding, 8 preset constant arrays (13-bit), state enum
//   {IDLE, WAIT_VS, HOLD, SETTLE}, 13-bit timing typedef.
//  One sub-module tmc_mode_rom: 2-bit mode -> eight 13-bit timing values, purely combinational; registered in the parent.
// TESTING
//  1 reset, clk_locked=1, tg_vs every 1000 cycles -> tg_blank=1 until 2nd vs_rise, then 0; h_active=1920; no cfg_ack.
//  2 cfg_req mode=1 in IDLE -> busy; tg_rst_n=0 at next vs_rise; lock held 255 cycles -> release; blank 2 frames;
//    one cfg_ack; h_active=1280, v_active=720, clk_sel=1.
//  3 cfg_req mode=cur_mode -> cfg_ack 1 cycle later; tg_rst_n and tg_blank unchanged.
//  4 request mode=2 with clk_locked=0 throughout (LOCK_TIMEOUT=1000) -> cfg_err after 1000 cycles; mode/clk_sel back
//    to previous; settle blank; no cfg_ack.
//  5 clk_locked glitches low at count 200 -> lock_cnt restarts; release exactly 255 cycles after last rising edge.
//    Also: cfg_req pulses during HOLD are ignored.
//  6 assert sys_rst_n mid-HOLD -> all outputs at reset values asynchronously.
//    Under TMC_FRAME_CNT_EN: frame_cnt counts vs_rise and clears on HOLD entry.

Source files
------------

// File: rtl/timing_mode_pkg.sv
// Shared types, mode encoding and timing presets for the video mode controller.
// Latency: n/a (constants and a pure lookup function).
// Backpressure: n/a.
package timing_mode_pkg;

    typedef logic [1:0]  mode_t;
    typedef logic [12:0] timing_t;

    localparam mode_t MODE_1920X1080 = 2'd0;
    localparam mode_t MODE_1280X720  = 2'd1;
    localparam mode_t MODE_640X480   = 2'd2;
    localparam mode_t MODE_800X600   = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        HOLD    = 2'd2,
        SETTLE  = 2'd3
    } state_t;

    typedef struct packed {
        timing_t h_front;
        timing_t h_sync;
        timing_t h_back;
        timing_t h_active;
        timing_t v_front;
        timing_t v_sync;
        timing_t v_back;
        timing_t v_active;
    } preset_t;

    // Indexed by mode: 1080p, 720p, 480p, 600p.
    localparam timing_t H_FRONT_TBL  [4] = '{13'd88,   13'd110,  13'd16,  13'd40};
    localparam timing_t H_SYNC_TBL   [4] = '{13'd44,   13'd40,   13'd96,  13'd128};
    localparam timing_t H_BACK_TBL   [4] = '{13'd148,  13'd220,  13'd48,  13'd88};
    localparam timing_t H_ACTIVE_TBL [4] = '{13'd1920, 13'd1280, 13'd640, 13'd800};
    localparam timing_t V_FRONT_TBL  [4] = '{13'd4,    13'd5,    13'd10,  13'd1};
    localparam timing_t V_SYNC_TBL   [4] = '{13'd5,    13'd5,    13'd2,   13'd4};
    localparam timing_t V_BACK_TBL   [4] = '{13'd36,   13'd20,   13'd33,  13'd23};
    localparam timing_t V_ACTIVE_TBL [4] = '{13'd1080, 13'd720,  13'd480, 13'd600};

    function automatic preset_t preset_of(input mode_t m);
        preset_t p;
        p.h_front  = H_FRONT_TBL[m];
        p.h_sync   = H_SYNC_TBL[m];
        p.h_back   = H_BACK_TBL[m];
        p.h_active = H_ACTIVE_TBL[m];
        p.v_front  = V_FRONT_TBL[m];
        p.v_sync   = V_SYNC_TBL[m];
        p.v_back   = V_BACK_TBL[m];
        p.v_active = V_ACTIVE_TBL[m];
        return p;
    endfunction

endpackage

// File: rtl/timing_mode_ctrl_if.sv
// Mode-change request channel: level request plus ack/err pulses and busy status.
// Latency: n/a (wires only).
// Backpressure: requester watches busy; requests while busy are dropped by the controller.
interface timing_mode_ctrl_if;
    import timing_mode_pkg::*;

    logic  cfg_req;
    mode_t cfg_mode;
    logic  cfg_ack;
    logic  cfg_err;
    logic  cfg_busy;

    modport master (output cfg_req, output cfg_mode, input cfg_ack, input cfg_err, input cfg_busy);
    modport slave  (input cfg_req, input cfg_mode, output cfg_ack, output cfg_err, output cfg_busy);
endinterface

// File: rtl/tmc_mode_rom.sv
// Mode to timing-preset lookup table.
// Latency: combinational; the parent registers the result.
// Backpressure: none.
module tmc_mode_rom
    import timing_mode_pkg::*;
(
    input  mode_t   mode,
    output preset_t preset
);
    assign preset = preset_of(mode);
endmodule

// File: rtl/timing_mode_ctrl.sv
// Sequences video mode changes: wait for frame edge, hold generator in reset until PLL lock, blank while settling.
// Latency: ack <= wait-to-VS + LOCK_STABLE cycles + SETTLE_FRAMES frames + 2 cycles; err after LOCK_TIMEOUT cycles of HOLD.
// Backpressure: cfg_busy high outside IDLE; requests seen while busy are dropped. Optional TMC_FRAME_CNT_EN adds frame_cnt.
module timing_mode_ctrl
    import timing_mode_pkg::*;
#(
    parameter int DEFAULT_MODE  = 0,
    parameter int LOCK_STABLE   = 255,
    parameter int LOCK_TIMEOUT  = 2**20-1,
    parameter int SETTLE_FRAMES = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    timing_mode_ctrl_if.slave cfg,
    input  logic              tg_vs,
    input  logic              clk_locked,
    output mode_t             clk_sel,
    output logic              tg_rst_n,
    output logic              tg_blank,
    output timing_t           h_front,
    output timing_t           h_sync,
    output timing_t           h_back,
    output timing_t           h_active,
    output timing_t           v_front,
    output timing_t           v_sync,
    output timing_t           v_back,
    output timing_t           v_active,
    output logic [15:0]       frame_cnt
);

    localparam mode_t       DEF_MODE  = mode_t'(DEFAULT_MODE);
    localparam logic [7:0]  LOCK_LIM  = 8'(LOCK_STABLE);
    localparam logic [19:0] TO_LIM    = 20'(LOCK_TIMEOUT);
    localparam logic [3:0]  FRM_LIM   = 4'(SETTLE_FRAMES);

    state_t      state, state_nxt;
    mode_t       cur_mode, cur_mode_nxt;
    mode_t       new_mode, new_mode_nxt;
    mode_t       prev_mode, prev_mode_nxt;
    mode_t       clk_sel_q, clk_sel_nxt;
    logic        tg_rst_n_q, rst_nxt;
    logic        tg_blank_q, blank_nxt;
    logic        ack_q, ack_nxt;
    logic        err_q, err_nxt;
    logic        busy_q, busy_nxt;
    logic        ack_on_exit, ack_on_exit_nxt;
    logic [7:0]  lock_cnt, lock_cnt_nxt;
    logic [19:0] to_cnt, to_cnt_nxt;
    logic [3:0]  frm_cnt, frm_cnt_nxt;
    logic        tg_vs_d1;
    logic        vs_rise;
    preset_t     rom_preset;
    preset_t     timing_q;

    assign vs_rise = tg_vs & ~tg_vs_d1;

    tmc_mode_rom u_rom (
        .mode   (cur_mode),
        .preset (rom_preset)
    );

    // Next-state and next-output decode for the mode-change sequence.
    always_comb begin
        state_nxt       = state;
        cur_mode_nxt    = cur_mode;
        new_mode_nxt    = new_mode;
        prev_mode_nxt   = prev_mode;
        clk_sel_nxt     = clk_sel_q;
        rst_nxt         = tg_rst_n_q;
        blank_nxt       = tg_blank_q;
        lock_cnt_nxt    = lock_cnt;
        to_cnt_nxt      = to_cnt;
        frm_cnt_nxt     = frm_cnt;
        ack_on_exit_nxt = ack_on_exit;
        ack_nxt         = 1'b0;
        err_nxt         = 1'b0;
        case (state)
            IDLE: begin
                if (cfg.cfg_req) begin
                    if (cfg.cfg_mode == cur_mode) begin
                        ack_nxt = 1'b1;
                    end else begin
                        new_mode_nxt  = cfg.cfg_mode;
                        prev_mode_nxt = cur_mode;
                        state_nxt     = WAIT_VS;
                    end
                end
            end
            WAIT_VS: begin
                if (vs_rise) begin
                    state_nxt    = HOLD;
                    rst_nxt      = 1'b0;
                    blank_nxt    = 1'b1;
                    clk_sel_nxt  = new_mode;
                    cur_mode_nxt = new_mode;
                    lock_cnt_nxt = 8'd0;
                    to_cnt_nxt   = 20'd0;
                end
            end
            HOLD: begin
                to_cnt_nxt   = to_cnt + 20'd1;
                lock_cnt_nxt = clk_locked ? lock_cnt + 8'd1 : 8'd0;
                // Lock is checked first so a lock landing on the timeout cycle still succeeds.
                if (lock_cnt_nxt == LOCK_LIM) begin
                    rst_nxt         = 1'b1;
                    frm_cnt_nxt     = 4'd0;
                    ack_on_exit_nxt = 1'b1;
                    state_nxt       = SETTLE;
                end else if (to_cnt_nxt == TO_LIM) begin
                    cur_mode_nxt    = prev_mode;
                    clk_sel_nxt     = prev_mode;
                    rst_nxt         = 1'b1;
                    err_nxt         = 1'b1;
                    frm_cnt_nxt     = 4'd0;
                    ack_on_exit_nxt = 1'b0;
                    state_nxt       = SETTLE;
                end
            end
            SETTLE: begin
                if (vs_rise) begin
                    if (frm_cnt + 4'd1 == FRM_LIM) begin
                        blank_nxt = 1'b0;
                        ack_nxt   = ack_on_exit;
                        state_nxt = IDLE;
                    end else begin
                        frm_cnt_nxt = frm_cnt + 4'd1;
                    end
                end
            end
            default: state_nxt = SETTLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    // State and registered outputs; reset parks in SETTLE with the default mode blanked.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= SETTLE;
            cur_mode    <= DEF_MODE;
            new_mode    <= DEF_MODE;
            prev_mode   <= DEF_MODE;
            clk_sel_q   <= DEF_MODE;
            tg_rst_n_q  <= 1'b1;
            tg_blank_q  <= 1'b1;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b1;
            ack_on_exit <= 1'b0;
            lock_cnt    <= 8'd0;
            to_cnt      <= 20'd0;
            frm_cnt     <= 4'd0;
            tg_vs_d1    <= 1'b0;
            timing_q    <= preset_of(DEF_MODE);
        end else begin
            state       <= state_nxt;
            cur_mode    <= cur_mode_nxt;
            new_mode    <= new_mode_nxt;
            prev_mode   <= prev_mode_nxt;
            clk_sel_q   <= clk_sel_nxt;
            tg_rst_n_q  <= rst_nxt;
            tg_blank_q  <= blank_nxt;
            ack_q       <= ack_nxt;
            err_q       <= err_nxt;
            busy_q      <= busy_nxt;
            ack_on_exit <= ack_on_exit_nxt;
            lock_cnt    <= lock_cnt_nxt;
            to_cnt      <= to_cnt_nxt;
            frm_cnt     <= frm_cnt_nxt;
            tg_vs_d1    <= tg_vs;
            timing_q    <= rom_preset;
        end
    end

`ifdef TMC_FRAME_CNT_EN
    logic        hold_entry;
    logic [15:0] frame_cnt_q;

    assign hold_entry = (state == WAIT_VS) && vs_rise;

    // Saturating frame counter, restarted whenever a mode change enters HOLD.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            frame_cnt_q <= 16'd0;
        end else if (hold_entry) begin
            frame_cnt_q <= 16'd0;
        end else if (vs_rise && frame_cnt_q != 16'hFFFF) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = 16'd0;
`endif

    assign cfg.cfg_ack  = ack_q;
    assign cfg.cfg_err  = err_q;
    assign cfg.cfg_busy = busy_q;
    assign clk_sel      = clk_sel_q;
    assign tg_rst_n     = tg_rst_n_q;
    assign tg_blank     = tg_blank_q;
    assign h_front      = timing_q.h_front;
    assign h_sync       = timing_q.h_sync;
    assign h_back       = timing_q.h_back;
    assign h_active     = timing_q.h_active;
    assign v_front      = timing_q.v_front;
    assign v_sync       = timing_q.v_sync;
    assign v_back       = timing_q.v_back;
    assign v_active     = timing_q.v_active;

endmodule
